// File: rtl/servo_pulse_meter.sv
`default_nettype none
// ============================================================================
//  Module   : servo_pulse_meter
//  Purpose  : Measures servo PWM high time and frame period, quantises the
//             high time into an angle index 0..20, flags out-of-range widths
//             and reports loss of signal.
//  Options  : PULSE_METER_FILTER_EN - 3-sample majority glitch filter on the
//             synchronised input (adds 2 clocks of uniform delay).
//  Revision : 1.0 - initial release
// ============================================================================
module servo_pulse_meter #(
   parameter int CLK_PER_FRAME = 1000000,
   parameter int MIN_WIDTH     = 25000,
   parameter int MAX_WIDTH     = 125000,
   parameter int STEP          = 5000,
   parameter int TIMEOUT       = 2000000
) (
   input  logic        CLOCK_50,
   input  logic        RESET,
   input  logic        pwm_in,
   output logic [17:0] width,
   output logic [20:0] period,
   output logic [4:0]  angle_idx,
   output logic        valid,
   output logic        range_err,
   output logic        lost
);

   localparam int                c_TW     = $clog2(TIMEOUT + 1);
   localparam logic [18:0]       c_min    = 19'(MIN_WIDTH);
   localparam logic [18:0]       c_max    = 19'(MAX_WIDTH);
   localparam logic [18:0]       c_step   = 19'(STEP);
   localparam logic [18:0]       c_half   = 19'(STEP / 2);
   localparam logic [c_TW-1:0]   c_to_max = c_TW'(TIMEOUT);
   localparam logic [c_TW-1:0]   c_to_end = c_TW'(TIMEOUT - 1);

   // Nominal frame must fit the period counter; width range must be ordered.
   if (MIN_WIDTH >= MAX_WIDTH || STEP < 2 || TIMEOUT < 2 ||
       CLK_PER_FRAME >= (1 << 21)) begin : g_param_err
      $error("servo_pulse_meter: inconsistent parameters");
   end

   typedef enum logic [1:0] {
      WAIT_RISE = 2'd0,
      HIGH      = 2'd1,
      LOW       = 2'd2,
      CALC      = 2'd3
   } state_t;

   state_t            r_state, w_next;
   logic              r_sync1, r_sync2, r_in_d;
   logic              w_in, w_rise, w_fall, w_timeout, w_done;
   logic [17:0]       r_wcnt, r_sh_w, r_cw;
   logic [20:0]       r_pcnt, r_sh_p;
   logic [18:0]       r_rem, w_rem_init;
   logic [4:0]        r_q;
   logic              r_fell;
   logic [c_TW-1:0]   r_tcnt;

   // Two-flop synchroniser for the asynchronous PWM input.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pwm_in;
         r_sync2 <= r_sync1;
      end
   end

`ifdef PULSE_METER_FILTER_EN
   logic r_f1, r_f2, r_filt;

   // Majority of three consecutive samples; a lone 1-clock pulse never wins.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         r_f1   <= 1'b0;
         r_f2   <= 1'b0;
         r_filt <= 1'b0;
      end else begin
         r_f1   <= r_sync2;
         r_f2   <= r_f1;
         r_filt <= (r_sync2 & r_f1) | (r_sync2 & r_f2) | (r_f1 & r_f2);
      end
   end
   assign w_in = r_filt;
`else
   assign w_in = r_sync2;
`endif

   // Delayed copy of the conditioned input for edge detection.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) r_in_d <= 1'b0;
      else       r_in_d <= w_in;
   end

   assign w_rise     = w_in & ~r_in_d;
   assign w_fall     = ~w_in & r_in_d;
   assign w_timeout  = (r_tcnt == c_to_end) && !w_rise;
   assign w_done     = (r_state == CALC) && !((r_rem >= c_step) && (r_q < 5'd20));
   assign w_rem_init = ({1'b0, r_sh_w} < c_min) ? 19'd0 : ({1'b0, r_sh_w} - c_min + c_half);

   // State register.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) r_state <= WAIT_RISE;
      else       r_state <= w_next;
   end

   // Next-state logic; a timeout always abandons the frame in progress.
   always_comb begin
      w_next = r_state;
      if (w_timeout) begin
         w_next = WAIT_RISE;
      end else begin
         case (r_state)
            WAIT_RISE: if (w_rise) w_next = HIGH;
            HIGH:      if (w_fall) w_next = LOW;
            LOW:       if (w_rise) w_next = CALC;
            CALC:      if (w_done) w_next = (r_fell || w_fall) ? LOW : HIGH;
            default:   w_next = WAIT_RISE;
         endcase
      end
   end

   // Counters, shadow registers, divider and result outputs.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         r_wcnt    <= '0;
         r_pcnt    <= '0;
         r_sh_w    <= '0;
         r_sh_p    <= '0;
         r_cw      <= '0;
         r_rem     <= '0;
         r_q       <= '0;
         r_fell    <= 1'b0;
         r_tcnt    <= '0;
         width     <= '0;
         period    <= '0;
         angle_idx <= '0;
         valid     <= 1'b0;
         range_err <= 1'b0;
         lost      <= 1'b0;
      end else begin
         valid <= 1'b0;

         if (w_rise)                  r_tcnt <= '0;
         else if (r_tcnt != c_to_max) r_tcnt <= r_tcnt + c_TW'(1);

         if (w_rise)         lost <= 1'b0;
         else if (w_timeout) lost <= 1'b1;

         case (r_state)
            WAIT_RISE: begin
               if (w_rise) begin
                  r_wcnt <= 18'd1;
                  r_pcnt <= 21'd1;
               end
            end
            HIGH: begin
               if (~&r_wcnt) r_wcnt <= r_wcnt + 18'd1;
               if (~&r_pcnt) r_pcnt <= r_pcnt + 21'd1;
               if (w_fall)   r_sh_w <= r_wcnt;
            end
            LOW: begin
               if (w_rise) begin
                  // Close the frame; the next one starts counting right away.
                  r_sh_p <= r_pcnt;
                  r_cw   <= r_sh_w;
                  r_rem  <= w_rem_init;
                  r_q    <= 5'd0;
                  r_fell <= 1'b0;
                  r_wcnt <= 18'd1;
                  r_pcnt <= 21'd1;
               end else begin
                  if (~&r_wcnt) r_wcnt <= r_wcnt + 18'd1;
                  if (~&r_pcnt) r_pcnt <= r_pcnt + 21'd1;
               end
            end
            CALC: begin
               if (~&r_wcnt) r_wcnt <= r_wcnt + 18'd1;
               if (~&r_pcnt) r_pcnt <= r_pcnt + 21'd1;
               if (w_fall) begin
                  r_sh_w <= r_wcnt;
                  r_fell <= 1'b1;
               end
               if (w_done) begin
                  if (!w_timeout) begin
                     width  <= r_cw;
                     period <= r_sh_p;
                     valid  <= 1'b1;
                     if ({1'b0, r_cw} < c_min) begin
                        angle_idx <= 5'd0;
                        range_err <= 1'b1;
                     end else if ({1'b0, r_cw} > c_max) begin
                        angle_idx <= 5'd20;
                        range_err <= 1'b1;
                     end else begin
                        angle_idx <= r_q;
                        range_err <= 1'b0;
                     end
                  end
               end else begin
                  r_rem <= r_rem - c_step;
                  r_q   <= r_q + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_servo_pulse_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_servo_pulse_meter
//  Purpose  : Self-checking bench for servo_pulse_meter. A waveform-level
//             model measures each frame from the driven pwm_in samples and
//             predicts every valid result.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_servo_pulse_meter;

   localparam int MINW  = 250;
   localparam int MAXW  = 1250;
   localparam int STP   = 50;
   localparam int TO    = 3000;
   localparam int FRAME = 2000;
`ifdef PULSE_METER_FILTER_EN
   localparam int LAT   = 27;
`else
   localparam int LAT   = 25;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pwm = 1'b0;
   logic [17:0] width;
   logic [20:0] period;
   logic [4:0]  angle_idx;
   logic        valid, range_err, lost;

   typedef struct {
      int w;
      int p;
   } frame_t;

   frame_t exp_q[$];
   int     checks = 0;
   int     errors = 0;
   int     since  = 0;

   servo_pulse_meter #(
      .CLK_PER_FRAME(FRAME), .MIN_WIDTH(MINW), .MAX_WIDTH(MAXW),
      .STEP(STP), .TIMEOUT(TO)
   ) dut (
      .CLOCK_50(clk), .RESET(rst), .pwm_in(pwm),
      .width(width), .period(period), .angle_idx(angle_idx),
      .valid(valid), .range_err(range_err), .lost(lost)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input int n);
      pwm = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic frame(input int hi, input int per);
      drive(1'b1, hi);
      drive(1'b0, per - hi);
   endtask

   initial begin
      fork
         // Reference model: measures frames from sampled pwm levels.
         begin : model
            logic       prev, s, started, fell;
            logic [2:0] hist;
            int         hi_c, per_c;
            prev = 0; started = 0; fell = 0; hist = 0; hi_c = 0; per_c = 0;
            forever begin
               @(posedge clk);
               if (rst) begin
                  prev = 0; started = 0; hist = 0; since = 0;
                  exp_q.delete();
               end else begin
                  s = pwm;
`ifdef PULSE_METER_FILTER_EN
                  hist = {hist[1:0], pwm};
                  s = (hist[0] & hist[1]) | (hist[1] & hist[2]) | (hist[0] & hist[2]);
`endif
                  if (s && !prev) begin
                     if (started) exp_q.push_back('{hi_c, per_c});
                     started = 1; fell = 0; hi_c = 1; per_c = 1; since = 0;
                  end else begin
                     per_c++;
                     if (!s) fell = 1;
                     else if (!fell) hi_c++;
                     since++;
                     if (since >= TO) started = 0;
                  end
                  prev = s;
               end
            end
         end
         // Result monitor: every valid must match the oldest predicted frame.
         begin : monitor
            frame_t f;
            int     ea;
            forever begin
               @(negedge clk);
               if (valid === 1'b1) begin
                  check("valid_expected", exp_q.size() != 0, 1);
                  check("latency", since <= LAT, 1);
                  if (exp_q.size() != 0) begin
                     f = exp_q.pop_front();
                     if (f.w < MINW)      ea = 0;
                     else if (f.w > MAXW) ea = 20;
                     else                 ea = ((f.w - MINW + STP / 2) / STP > 20) ? 20 : (f.w - MINW + STP / 2) / STP;
                     check("width", width, f.w);
                     check("period", period, f.p);
                     check("angle_idx", angle_idx, ea);
                     check("range_err", range_err, (f.w < MINW || f.w > MAXW) ? 1 : 0);
                  end
               end
            end
         end
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_width", width, 0);
      check("rst_period", period, 0);
      check("rst_angle", angle_idx, 0);
      check("rst_valid", valid, 0);
      check("rst_range", range_err, 0);
      check("rst_lost", lost, 0);
      rst = 1'b0;
      drive(1'b0, 5);

      // Directed widths, including boundaries and out-of-range cases
      frame(250, FRAME);
      frame(250, FRAME);
      frame(750, FRAME);
      frame(1250, FRAME);
      frame(774, FRAME);
      frame(776, FRAME);
      frame(100, FRAME);
      frame(1300, FRAME);
      frame(500, FRAME);
      frame(249, FRAME);
      frame(1251, FRAME);

      // Randomised frames
      for (int i = 0; i < 10; i++) begin
         int hi;
         hi = $urandom_range(150, 1350);
         frame(hi, hi + $urandom_range(100, 600));
      end
      check("lost_before", lost, 0);

      // Loss of signal with input held low, then held high
      drive(1'b0, 3500);
      check("lost_low", lost, 1);
      drive(1'b1, 5);
      check("lost_clear_high", lost, 0);
      drive(1'b1, 3495);
      check("lost_high", lost, 1);
      drive(1'b0, 500);
      frame(600, FRAME);
      check("lost_recover", lost, 0);
      frame(900, FRAME);
      frame(400, FRAME);

      // Reset in the middle of a pulse
      check("q_empty_pre_reset", exp_q.size(), 0);
      drive(1'b1, 400);
      rst = 1'b1;
      drive(1'b1, 2);
      check("midrst_width", width, 0);
      check("midrst_period", period, 0);
      check("midrst_angle", angle_idx, 0);
      check("midrst_valid", valid, 0);
      check("midrst_range", range_err, 0);
      check("midrst_lost", lost, 0);
      rst = 1'b0;
      drive(1'b1, 348);
      drive(1'b0, 1250);
      frame(700, FRAME);
      frame(800, FRAME);

      // One-clock low glitch in the middle of a 750 pulse
      drive(1'b1, 375);
      drive(1'b0, 1);
      drive(1'b1, 374);
      drive(1'b0, 1250);
      frame(600, FRAME);

      // Closing edge for the last frame, then drain
      drive(1'b1, 40);
      drive(1'b0, 20);
      check("q_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/servo_pulse_meter.md
SERVO_PULSE_METER -- requirements
Module: servo_pulse_meter

Interface
REQ-001 Parameter CLK_PER_FRAME, default 1000000, nominal frame length in clocks (20 ms at 50 MHz).
REQ-002 Parameter MIN_WIDTH, default 25000, pulse width for angle 0.
REQ-003 Parameter MAX_WIDTH, default 125000, pulse width for angle 180.
REQ-004 Parameter STEP, default 5000, width per angle index (9 degrees).
REQ-005 Parameter TIMEOUT, default 2000000, clocks without a rising edge before signal-lost.
REQ-006 CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-007 RESET  in  1  asynchronous, active-high reset.
REQ-008 pwm_in  in  1  asynchronous servo PWM input, e.g. GPIO_0[0] from the servo pulse generator.
REQ-009 width  out  18  last measured high time, in clocks.
REQ-010 period  out  21  last measured rising-to-rising time, in clocks.
REQ-011 angle_idx  out  5  quantised angle index 0..20.
REQ-012 valid  out  1  one-cycle strobe: width/period/angle_idx updated.
REQ-013 range_err  out  1  sticky-until-next-frame: width outside MIN_WIDTH..MAX_WIDTH.
REQ-014 lost  out  1  high while no rising edge seen for TIMEOUT clocks.

Function
REQ-015 pwm_in SHALL pass through a 2-flop synchroniser; edge detection SHALL use the synchronised signal and its 1-cycle delayed copy.
REQ-016 FSM states: WAIT_RISE, HIGH, LOW, CALC.
REQ-017 WAIT_RISE: on rising edge, clear width/period counters to 1, go HIGH.
REQ-018 HIGH: increment both counters each cycle; on falling edge latch width counter into a shadow register, go LOW.
REQ-019 LOW: increment period counter; on rising edge latch period counter into shadow, restart both counters at 1, go CALC while a new frame begins measuring in parallel.
REQ-020 CALC: angle index computed by iterative subtraction of STEP from (shadow width - MIN_WIDTH + STEP/2), one subtraction per cycle, at most 21 cycles; result clamped to 20.
REQ-021 When CALC completes: width, period, angle_idx, range_err update together and valid pulses for exactly one cycle; FSM returns to HIGH (or LOW if the falling edge has already occurred, with shadow width captured).
REQ-022 Latency: valid asserts no later than 24 clocks after the synchronised rising edge closing a frame.
REQ-023 width < MIN_WIDTH -> angle_idx 0, range_err 1; width > MAX_WIDTH -> angle_idx 20, range_err 1; otherwise range_err 0.
REQ-024 Counters SHALL saturate at all-ones, never wrap.
REQ-025 Timeout counter clears on every synchronised rising edge; at TIMEOUT, lost asserts, FSM goes WAIT_RISE, no valid issued for the partial frame.
REQ-026 lost deasserts on the first rising edge after it asserted; the first frame after recovery is measured normally.
REQ-027 First rising edge after reset SHALL NOT produce valid; first valid follows the second rising edge.
REQ-028 pwm_in held high continuously -> lost after TIMEOUT; held low -> lost after TIMEOUT.

Reset
REQ-029 RESET asserted: FSM WAIT_RISE; synchroniser, counters, shadows cleared; width 0, period 0, angle_idx 0, valid 0, range_err 0, lost 0.
REQ-030 RESET mid-frame SHALL discard the partial measurement; no valid until two full rising edges after release.

Configuration
REQ-031 Macro PULSE_METER_FILTER_EN defined: synchronised input passes a 3-sample majority glitch filter before edge detection, adding 2 clocks uniform delay; pulses of 1 clock are ignored.
REQ-032 PULSE_METER_FILTER_EN undefined: no filter; every synchronised transition is an edge.

Verification
REQ-033 Frames: 25000 high / 1000000 period, repeated -> valid each frame, width 25000, period 1000000, angle_idx 0, range_err 0.
REQ-034 Width 75000 -> angle_idx 10; width 125000 -> angle_idx 20; width 77400 -> angle_idx 10; width 77600 -> angle_idx 11.
REQ-035 Width 10000 -> angle_idx 0, range_err 1; width 130000 -> angle_idx 20, range_err 1; next 50000 frame clears range_err, angle_idx 5.
REQ-036 Stop pwm_in low for 2000000 clocks -> lost 1, no valid; resume frames -> lost 0 on first rising edge, valid after second.
REQ-037 RESET pulse at clock 40000 of a 75000 pulse -> all outputs 0, first valid after two subsequent rising edges.
REQ-038 With PULSE_METER_FILTER_EN: inject 1-clock low glitch mid-pulse of 75000 -> width 75000; without it -> width recorded up to glitch.
